// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-RAM access controller: FSM states,
// grant ids, default RAM geometry and the address check helper.
package dmem_ctrl_pkg;

    localparam int DMEM_ADDR_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_t;

    typedef enum logic {
        GNT_MS  = 1'b0,
        GNT_DBG = 1'b1
    } dmem_gnt_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Misaligned byte address, or any bit set above the RAM's byte range.
    function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_arb.sv
// Mem-stage / debug-port arbiter. Mem stage wins by default; debug wins when
// alone, or after STARVE_LIM consecutive denials. Only built with DMEM_DBG_PORT_EN.
module dmem_arb
    import dmem_ctrl_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sample,
    input  logic      ms_req,
    input  logic      dbg_req,
    output dmem_gnt_t gnt
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_LIM));

    // Priority: debug only when alone or starved
    always_comb begin
        gnt = GNT_MS;
        if (dbg_req && (!ms_req || starved))
            gnt = GNT_DBG;
    end

    // Count consecutive debug denials; any debug grant or idle debug side clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (sample) begin
            if (!dbg_req || gnt == GNT_DBG)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-RAM access sequencer for the memory stage, optionally sharing the RAM
// with a debug loader port (build with DMEM_DBG_PORT_EN to add the dbg_* port
// and the starvation-aware arbiter). Requests are held until the one-cycle
// ms_ready / dbg_ack pulse; bad addresses complete without touching the RAM.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
`ifdef DMEM_DBG_PORT_EN
    parameter int STARVE_LIM = 4,
`endif
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ms_req,
    input  logic              ms_we,
    input  logic [31:0]       ms_addr,
    input  logic [31:0]       ms_wdata,
    output logic [31:0]       ms_rdata,
    output logic              ms_ready,
    output logic              ms_err,
`ifdef DMEM_DBG_PORT_EN
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // WAIT covers RD_LAT-1 cycles; the counter is loaded with one less than that
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_INIT = WCW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    dmem_state_t    state;
    logic [WCW-1:0] wait_cnt;
    dmem_gnt_t      gnt, gnt_q, resp_gnt;
    logic           we_q, err_q;
    logic [31:0]    ms_rdata_q;
    dmem_req_t      win;
    logic           req_any, win_bad;
    logic           enter_resp, resp_err, load_done;

`ifdef DMEM_DBG_PORT_EN
    logic [31:0] dbg_rdata_q;

    dmem_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (state == ST_IDLE),
        .ms_req  (ms_req),
        .dbg_req (dbg_req),
        .gnt     (gnt)
    );

    assign req_any = ms_req | dbg_req;

    // Winner's request fields
    always_comb begin
        if (gnt == GNT_DBG)
            win = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
        else
            win = '{we: ms_we, addr: ms_addr, wdata: ms_wdata};
    end
`else
    assign gnt     = GNT_MS;
    assign req_any = ms_req;

    // Mem stage is the only requester
    always_comb begin
        win = '{we: ms_we, addr: ms_addr, wdata: ms_wdata};
    end
`endif

    assign win_bad   = addr_bad(win.addr, ADDR_W);
    assign load_done = (state == ST_RESP) && !we_q && !err_q;

    // Decide whether the next edge moves into RESP, for whom, and with which flag
    always_comb begin
        enter_resp = 1'b0;
        resp_gnt   = gnt_q;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                resp_gnt   = gnt;
                enter_resp = req_any && win_bad;
                resp_err   = 1'b1;
            end
            ST_ACCESS: enter_resp = (RD_LAT == 1);
            ST_WAIT:   enter_resp = (wait_cnt == '0);
            default:   ;
        endcase
    end

    // Main sequencer: IDLE -> ACCESS -> WAIT -> RESP -> IDLE, registered RAM strobes and mem-stage handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            gnt_q      <= GNT_MS;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ms_ready   <= 1'b0;
            ms_err     <= 1'b0;
            ms_rdata_q <= '0;
        end else begin
            ms_ready <= enter_resp && (resp_gnt == GNT_MS);
            ms_err   <= enter_resp && resp_err && (resp_gnt == GNT_MS);
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        gnt_q     <= gnt;
                        we_q      <= win.we;
                        err_q     <= win_bad;
                        ram_addr  <= win.addr[ADDR_W+1:2];
                        ram_wdata <= win.wdata;
                        if (win_bad) begin
                            state <= ST_RESP;
                        end else begin
                            state  <= ST_ACCESS;
                            ram_en <= 1'b1;
                            ram_we <= win.we;
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (RD_LAT > 1) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0)
                        state <= ST_RESP;
                    else
                        wait_cnt <= wait_cnt - WCW'(1);
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (load_done && gnt_q == GNT_MS)
                        ms_rdata_q <= ram_rdata;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load data is passed through during RESP and held afterwards
    assign ms_rdata = (load_done && gnt_q == GNT_MS) ? ram_rdata : ms_rdata_q;

`ifdef DMEM_DBG_PORT_EN
    // Debug handshake and held read data; debug errors ack without a flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ack     <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack <= enter_resp && (resp_gnt == GNT_DBG);
            if (load_done && gnt_q == GNT_DBG)
                dbg_rdata_q <= ram_rdata;
        end
    end

    assign dbg_rdata = (load_done && gnt_q == GNT_DBG) ? ram_rdata : dbg_rdata_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each
// with its own RAM model. Stimulus pushes expected responses; a negedge monitor
// pops and checks data, error flag, port, RAM strobes and latency.
// Debug-port tests are compiled only with DMEM_DBG_PORT_EN.
module tb_dmem_ctrl;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic              ms_req [2];
    logic              ms_we [2];
    logic [31:0]       ms_addr [2];
    logic [31:0]       ms_wdata [2];
    logic [31:0]       ms_rdata [2];
    logic              ms_ready [2];
    logic              ms_err [2];
    logic              ram_en [2];
    logic              ram_we [2];
    logic [AW-1:0]     ram_addr [2];
    logic [31:0]       ram_wdata [2];
    logic [31:0]       ram_rdata [2];
`ifdef DMEM_DBG_PORT_EN
    logic              dbg_req [2];
    logic              dbg_we [2];
    logic [31:0]       dbg_addr [2];
    logic [31:0]       dbg_wdata [2];
    logic [31:0]       dbg_rdata [2];
    logic              dbg_ack [2];
`endif

    dmem_ctrl #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ms_req(ms_req[0]), .ms_we(ms_we[0]), .ms_addr(ms_addr[0]), .ms_wdata(ms_wdata[0]),
        .ms_rdata(ms_rdata[0]), .ms_ready(ms_ready[0]), .ms_err(ms_err[0]),
`ifdef DMEM_DBG_PORT_EN
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
`endif
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    dmem_ctrl #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .ms_req(ms_req[1]), .ms_we(ms_we[1]), .ms_addr(ms_addr[1]), .ms_wdata(ms_wdata[1]),
        .ms_rdata(ms_rdata[1]), .ms_ready(ms_ready[1]), .ms_err(ms_err[1]),
`ifdef DMEM_DBG_PORT_EN
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
`endif
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // RAM models: write on the strobe edge, read data valid RD_LAT cycles later, junk otherwise
    logic [31:0] mem [2][2**AW];
    logic [31:0] rp [2][3];
    logic        rv [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_en[k] && ram_we[k]) mem[k][ram_addr[k]] <= ram_wdata[k];
            rp[k][0] <= mem[k][ram_addr[k]];
            rv[k][0] <= ram_en[k] && !ram_we[k];
            rp[k][1] <= rp[k][0];
            rv[k][1] <= rv[k][0];
            rp[k][2] <= rp[k][1];
            rv[k][2] <= rv[k][1];
        end
    end

    assign ram_rdata[0] = rv[0][0] ? rp[0][0] : 32'hBADB_AD00;
    assign ram_rdata[1] = rv[1][2] ? rp[1][2] : 32'hBADB_AD00;

    // Scoreboard
    typedef struct {
        bit            dbg;
        bit            we;
        bit            err;
        logic [31:0]   rdata;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
        int            t0;
        int            lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   en_cnt [2];
    int   we_cnt [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen or missing, cycle %0d", nm, cyc);
    endtask

    function automatic exp_t mk(input bit dbg, input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input bit err, input int lat);
        exp_t e;
        e.dbg = dbg; e.we = we; e.err = err; e.rdata = rd;
        e.waddr = addr[AW+1:2]; e.wdata = wd; e.t0 = cyc; e.lat = lat;
        return e;
    endfunction

    // Monitor: checks RAM strobes against the pending entry and pops on each completion
    always @(negedge clk) begin
        exp_t        e;
        bit          have, r_ms, r_dbg;
        logic [31:0] rd;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                en_cnt[k] = 0;
                we_cnt[k] = 0;
                if (k == 0) sb0.delete(); else sb1.delete();
                continue;
            end
            have = (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (have) e = (k == 0) ? sb0[0] : sb1[0];
            if (ram_en[k]) begin
                en_cnt[k]++;
                if (ram_we[k]) we_cnt[k]++;
                if (!have) fail("ram_en_unexpected");
                else begin
                    chk("ram_addr", 32'(ram_addr[k]), 32'(e.waddr));
                    if (ram_we[k]) chk("ram_wdata", ram_wdata[k], e.wdata);
                    if (e.lat != 0) chk("ram_en_cycle", 32'(cyc - e.t0), 32'd1);
                end
            end
            r_ms  = ms_ready[k];
            r_dbg = 1'b0;
`ifdef DMEM_DBG_PORT_EN
            r_dbg = dbg_ack[k];
`endif
            if (r_ms || r_dbg) begin
                if (!have) fail("resp_unexpected");
                else begin
                    if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                    chk("resp_port_is_dbg", 32'(r_dbg), 32'(e.dbg));
                    chk(r_ms ? "ms_err" : "ms_err_on_dbg", 32'(ms_err[k]), 32'(r_ms && e.err));
                    rd = ms_rdata[k];
`ifdef DMEM_DBG_PORT_EN
                    if (r_dbg) rd = dbg_rdata[k];
`endif
                    if (!e.we && !e.err) chk("rdata", rd, e.rdata);
                    chk("ram_en_count", 32'(en_cnt[k]), e.err ? 32'd0 : 32'd1);
                    chk("ram_we_count", 32'(we_cnt[k]), 32'(e.we && !e.err));
                    if (e.lat != 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                    en_cnt[k] = 0;
                    we_cnt[k] = 0;
                end
            end
        end
    end

    // Mem-stage access: hold the request until ms_ready, then leave one idle cycle
    task automatic ms_op(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input bit err);
        bit done = 1'b0;
        exp_t e = mk(1'b0, we, addr, wd, rd, err, err ? 1 : (k == 0 ? 2 : 4));
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
        ms_we[k] = we; ms_addr[k] = addr; ms_wdata[k] = wd; ms_req[k] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            done = ms_ready[k];
        end
        ms_req[k] = 1'b0;
        if (!done) fail("ms_timeout");
        @(posedge clk); #1;
    endtask

`ifdef DMEM_DBG_PORT_EN
    task automatic dbg_op(input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input bit err);
        bit done = 1'b0;
        sb0.push_back(mk(1'b1, we, addr, wd, rd, err, err ? 1 : 2));
        dbg_we[0] = we; dbg_addr[0] = addr; dbg_wdata[0] = wd; dbg_req[0] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            done = dbg_ack[0];
        end
        dbg_req[0] = 1'b0;
        if (!done) fail("dbg_timeout");
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        for (int k = 0; k < 2; k++) begin
            ms_req[k] = 1'b0; ms_we[k] = 1'b0; ms_addr[k] = '0; ms_wdata[k] = '0;
`ifdef DMEM_DBG_PORT_EN
            dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
`endif
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ms_ready", 32'(ms_ready[k]), 32'd0);
            chk("rst_ms_err", 32'(ms_err[k]), 32'd0);
            chk("rst_ram_en", 32'(ram_en[k]), 32'd0);
            chk("rst_ram_we", 32'(ram_we[k]), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr[k]), 32'd0);
            chk("rst_ram_wdata", ram_wdata[k], 32'd0);
            chk("rst_ms_rdata", ms_rdata[k], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Same directed sequence on both RAM latencies
        for (int k = 0; k < 2; k++) begin
            ms_op(k, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
            ms_op(k, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);
            ms_op(k, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h0, 1'b0);
            chk("rdata_hold_after_store", ms_rdata[k], 32'hDEAD_BEEF);
            ms_op(k, 1'b0, 32'h0000_0204, 32'h0, 32'h1234_5678, 1'b0);
            ms_op(k, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1'b1);
            chk("rdata_hold_after_err", ms_rdata[k], 32'h1234_5678);
            ms_op(k, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
            ms_op(k, 1'b1, 32'h0001_0100, 32'h5555_5555, 32'h0, 1'b1);
            ms_op(k, 1'b1, 32'h0000_0101, 32'h6666_6666, 32'h0, 1'b1);
            ms_op(k, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);
            ms_op(k, 1'b1, 32'h0000_FFFC, 32'hA5A5_5A5A, 32'h0, 1'b0);
            ms_op(k, 1'b0, 32'h0000_FFFC, 32'h0, 32'hA5A5_5A5A, 1'b0);
            ms_op(k, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        end

        // Reset during WAIT on the RD_LAT=3 instance drops the access
        sb1.push_back(mk(1'b0, 1'b0, 32'h0000_0204, 32'h0, 32'h0, 1'b0, 0));
        ms_we[1] = 1'b0; ms_addr[1] = 32'h0000_0204; ms_req[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        ms_req[1] = 1'b0;
        #1;
        chk("midrst_ram_en", 32'(ram_en[1]), 32'd0);
        chk("midrst_ms_ready", 32'(ms_ready[1]), 32'd0);
        chk("midrst_ms_rdata", ms_rdata[1], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ms_op(1, 1'b0, 32'h0000_0204, 32'h0, 32'h1234_5678, 1'b0);

`ifdef DMEM_DBG_PORT_EN
        // Debug port alone, shared RAM visibility, debug error acks without flag
        dbg_op(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b0);
        ms_op(0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0);
        dbg_op(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0);
        dbg_op(1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b1);
        chk("dbg_rdata_hold", dbg_rdata[0], 32'hCAFE_F00D);

        // Both held: four mem-stage grants, then debug
        for (int i = 0; i < 4; i++)
            sb0.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0));
        sb0.push_back(mk(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0, 0));
        ms_we[0] = 1'b0; ms_addr[0] = 32'h0000_0100;
        dbg_we[0] = 1'b0; dbg_addr[0] = 32'h0000_0300;
        ms_req[0] = 1'b1; dbg_req[0] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            done = dbg_ack[0];
        end
        ms_req[0] = 1'b0; dbg_req[0] = 1'b0;
        if (!done) fail("starve_timeout");
        @(posedge clk); #1;

        // Counter cleared by the debug grant: mem stage wins the next tie
        sb0.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0));
        sb0.push_back(mk(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0, 0));
        ms_req[0] = 1'b1; dbg_req[0] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            if (ms_ready[0]) ms_req[0] = 1'b0;
            if (dbg_ack[0]) done = 1'b1;
        end
        ms_req[0] = 1'b0; dbg_req[0] = 1'b0;
        if (!done) fail("post_starve_timeout");
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        if (sb0.size() != 0 || sb1.size() != 0) fail("sb_leftover");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
